// File: rtl/reg_pkg.sv
// Shared defaults and constants for the register-bank blocks.
package reg_pkg;

  localparam int REG_WIDTH_DEF = 16;
  localparam int REG_DEPTH_DEF = 8;
  localparam int REG_ADDR_DEF  = 3;

  // Widest data word any register block may use; slice REG_ZERO to the local width.
  localparam int                     REG_MAX_W = 64;
  localparam logic [REG_MAX_W-1:0]   REG_ZERO  = '0;

endpackage

// File: rtl/reg_cell.sv
// Single storage register with write/increment controls and all-ones wrap detect.
module reg_cell
  import reg_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_q,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_q <= REG_ZERO[WIDTH-1:0];
    else if (i_wr)
      r_q <= i_wdata;
    else if (i_inc)
      r_q <= r_q + WIDTH'(1);
  end

  // A write takes precedence, so an increment alongside it never wraps.
  assign o_wrap = i_inc & ~i_wr & (&r_q);
  assign o_q    = r_q;

endmodule

// File: rtl/reg_bank.sv
// Register bank: per-register cells, conflict-resolved write/increment, registered read mux.
module reg_bank
  import reg_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH_DEF,
  parameter int DEPTH  = REG_DEPTH_DEF,
  parameter int ADDR_W = REG_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  data_out,
  output logic              rd_valid,
  output logic              wrap,
  output logic              conflict
);

  logic [WIDTH-1:0] w_q [DEPTH];
  logic [DEPTH-1:0] w_wr;
  logic [DEPTH-1:0] w_inc;
  logic [DEPTH-1:0] w_cell_wrap;
  logic             w_conflict;

  logic [WIDTH-1:0] r_data_p1;
  logic             r_vld_p1;
  logic             r_wrap_p1;
  logic             r_conflict_p1;

  assign w_conflict = wr_en & inc_en & (wr_addr == inc_addr);

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    assign w_wr[g]  = wr_en & (wr_addr == ADDR_W'(g));
    assign w_inc[g] = inc_en & (inc_addr == ADDR_W'(g)) & ~w_conflict;

    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr    (w_wr[g]),
      .i_wdata (data_in),
      .i_inc   (w_inc[g]),
      .o_q     (w_q[g]),
      .o_wrap  (w_cell_wrap[g])
    );
  end

  // Stage p1: read data sampled before this edge's updates land, plus event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p1     <= REG_ZERO[WIDTH-1:0];
      r_vld_p1      <= 1'b0;
      r_wrap_p1     <= 1'b0;
      r_conflict_p1 <= 1'b0;
    end else begin
      r_data_p1     <= read_en ? w_q[rd_addr] : REG_ZERO[WIDTH-1:0];
      r_vld_p1      <= read_en;
      r_wrap_p1     <= |w_cell_wrap;
      r_conflict_p1 <= w_conflict;
    end
  end

  assign data_out = r_data_p1;
  assign rd_valid = r_vld_p1;
  assign wrap     = r_wrap_p1;
  assign conflict = r_conflict_p1;

endmodule

// File: tb/tb_reg_bank.sv
// Directed plus randomized bench for reg_bank against an array-based behavioural model.
module tb_reg_bank;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  data_in;
  logic              inc_en;
  logic [ADDR_W-1:0] inc_addr;
  logic              read_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  data_out;
  logic              rd_valid;
  logic              wrap;
  logic              conflict;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] exp_dout;
  logic             exp_vld, exp_wrap, exp_conf;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .data_in  (data_in),
    .inc_en   (inc_en),
    .inc_addr (inc_addr),
    .read_en  (read_en),
    .rd_addr  (rd_addr),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .wrap     (wrap),
    .conflict (conflict)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_vld));
    check({tag, ".wrap"},     32'(wrap),     32'(exp_wrap));
    check({tag, ".conflict"}, 32'(conflict), 32'(exp_conf));
  endtask

  // Called just after a rising edge; drives one cycle of inputs and checks the result after the next edge.
  task automatic do_cycle(input string tag,
                          input bit w, input int wa, input logic [WIDTH-1:0] wd,
                          input bit i, input int ia,
                          input bit r, input int ra);
    wr_en    = w;
    wr_addr  = ADDR_W'(wa);
    data_in  = wd;
    inc_en   = i;
    inc_addr = ADDR_W'(ia);
    read_en  = r;
    rd_addr  = ADDR_W'(ra);
    exp_vld  = r;
    exp_dout = r ? mem[ra] : '0;
    exp_conf = w && i && (wa == ia);
    exp_wrap = i && !exp_conf && (mem[ia] == {WIDTH{1'b1}});
    if (i && !exp_conf) mem[ia] = mem[ia] + 1'b1;
    if (w) mem[wa] = wd;
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    do_cycle(tag, 0, 0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;
    rst_n = 1'b0;
    {wr_en, inc_en, read_en} = '0;
    wr_addr = '0; inc_addr = '0; rd_addr = '0; data_in = '0;
    exp_dout = '0; exp_vld = 0; exp_wrap = 0; exp_conf = 0;

    #3;
    check_outputs("reset_hold");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write then read back with one-cycle latency.
    do_cycle("wr_1234", 1, 2, 16'h1234, 0, 0, 0, 0);
    do_cycle("rd_1234", 0, 0, '0, 0, 0, 1, 2);
    check("rd_1234.const", 32'(data_out), 32'h1234);
    idle("rd_1234_after");

    // All-ones increment wraps to zero.
    do_cycle("wr_ffff", 1, 5, 16'hFFFF, 0, 0, 0, 0);
    do_cycle("inc_wrap", 0, 0, '0, 1, 5, 0, 0);
    check("inc_wrap.const", 32'(wrap), 32'h1);
    do_cycle("rd_wrap", 0, 0, '0, 0, 0, 1, 5);
    check("rd_wrap.const", 32'(data_out), 32'h0);

    // Write and increment on the same address: write wins, conflict pulses.
    do_cycle("conflict", 1, 3, 16'h00AA, 1, 3, 0, 0);
    check("conflict.const", 32'(conflict), 32'h1);
    do_cycle("rd_conflict", 0, 0, '0, 0, 0, 1, 3);
    check("rd_conflict.const", 32'(data_out), 32'h00AA);

    // Conflicting increment on an all-ones register must not wrap.
    do_cycle("wr_ffff_b", 1, 6, 16'hFFFF, 0, 0, 0, 0);
    do_cycle("conflict_nowrap", 1, 6, 16'h0003, 1, 6, 0, 0);

    // Read-before-write on the same address.
    do_cycle("wr_10", 1, 1, 16'h0010, 0, 0, 0, 0);
    do_cycle("rbw", 1, 1, 16'h0020, 0, 0, 1, 1);
    check("rbw.const", 32'(data_out), 32'h0010);
    do_cycle("rbw_next", 0, 0, '0, 0, 0, 1, 1);
    check("rbw_next.const", 32'(data_out), 32'h0020);

    // Concurrent write and increment to different addresses.
    do_cycle("wr_9", 1, 7, 16'h0009, 0, 0, 0, 0);
    do_cycle("dual", 1, 0, 16'h0001, 1, 7, 0, 0);
    do_cycle("rd_r0", 0, 0, '0, 0, 0, 1, 0);
    check("rd_r0.const", 32'(data_out), 32'h0001);
    do_cycle("rd_r7", 0, 0, '0, 0, 0, 1, 7);
    check("rd_r7.const", 32'(data_out), 32'h000A);

    // Randomized traffic; write data is biased toward all-ones to exercise wrap.
    for (int n = 0; n < 400; n++) begin
      logic [WIDTH-1:0] wd;
      wd = ($urandom_range(0, 3) == 0) ? 16'hFFFF :
           ($urandom_range(0, 3) == 0) ? 16'hFFFE : WIDTH'($urandom);
      do_cycle("rand",
               bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)), wd,
               bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)),
               bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)));
    end

    // Asynchronous reset mid-cycle while reads stream.
    do_cycle("wr_7", 1, 4, 16'h0007, 0, 0, 0, 0);
    do_cycle("stream0", 0, 0, '0, 1, 2, 1, 4);
    wr_en = 1'b1; wr_addr = 3'd4; data_in = 16'h5555;
    inc_en = 1'b1; inc_addr = 3'd5; read_en = 1'b1; rd_addr = 3'd4;
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;
    exp_dout = '0; exp_vld = 0; exp_wrap = 0; exp_conf = 0;
    check_outputs("async_rst");
    @(posedge clk); #1;
    check_outputs("rst_held");
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k++)
      do_cycle("post_rst_rd", 0, 0, '0, 0, 0, 1, k);
    do_cycle("post_rst_wr", 1, 4, 16'hBEEF, 0, 0, 1, 4);
    do_cycle("post_rst_rd4", 0, 0, '0, 0, 0, 1, 4);
    check("post_rst_rd4.const", 32'(data_out), 32'hBEEF);
    idle("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
